sample_packer: RTL and testbench

//  Transmit-side gearbox for the equalizer tap datapath: packs a stream of single samples
//  (one per handshake) into MAIN_TAP-lane parallel words. Feeds the delay-line/window

---
 rtl/sample_packer.sv | 113 +++++++++++
 tb/tb_sample_packer.sv | 372 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sample_packer.sv
// Transmit-side gearbox: packs one-sample-per-handshake input into MAIN_TAP-lane words.
// Lane 0 holds the earliest sample; in_last closes a short, zero-padded word early.
module sample_packer #(
  parameter int MAIN_TAP         = 2,
  parameter int INPUT_DATA_WIDTH = 8,
  localparam int CNT_W           = $clog2(MAIN_TAP + 1)
) (
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic                                 in_valid,
  output logic                                 in_ready,
  input  logic [INPUT_DATA_WIDTH-1:0]          in_data,
  input  logic                                 in_last,
  output logic                                 out_valid,
  input  logic                                 out_ready,
  output logic [INPUT_DATA_WIDTH*MAIN_TAP-1:0] out_data,
  output logic                                 out_last,
  output logic [CNT_W-1:0]                     out_lanes,
  output logic [15:0]                          word_count
);

  localparam int W  = INPUT_DATA_WIDTH;
  localparam int DW = INPUT_DATA_WIDTH * MAIN_TAP;
  localparam logic [CNT_W-1:0] LAST_LANE = CNT_W'(MAIN_TAP - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [DW-1:0]    asm_q, asm_d;
  logic             out_valid_q, out_valid_d;
  logic [DW-1:0]    out_data_q, out_data_d;
  logic             out_last_q, out_last_d;
  logic [CNT_W-1:0] out_lanes_q, out_lanes_d;
  logic [15:0]      word_count_q, word_count_d;

  logic             closing_would_occur;
  logic             accept;
  logic             close;
  logic             xfer;
  logic [DW-1:0]    merged;
  logic [DW-1:0]    closed_word;

  // Only the closing sample can stall; filling lanes never waits on the output register.
  assign closing_would_occur = (cnt_q == LAST_LANE) || in_last;
  assign in_ready            = !closing_would_occur || !out_valid_q || out_ready;
  assign accept              = in_valid && in_ready;
  assign close               = accept && closing_would_occur;
  assign xfer                = out_valid_q && out_ready;

  generate
    for (genvar gi = 0; gi < MAIN_TAP; gi++) begin : g_lane
      assign merged[gi*W +: W] = (cnt_q == CNT_W'(gi)) ? in_data : asm_q[gi*W +: W];
      // Lanes beyond the closing sample are padding and must read as zero.
      assign closed_word[gi*W +: W] = (CNT_W'(gi) > cnt_q) ? '0 : merged[gi*W +: W];
    end
  endgenerate

  always_comb begin
    cnt_d = cnt_q;
    asm_d = asm_q;
    if (close) begin
      cnt_d = '0;
      asm_d = '0;
    end else if (accept) begin
      cnt_d = cnt_q + CNT_W'(1);
      asm_d = merged;
    end
  end

  always_comb begin
    out_valid_d  = out_valid_q;
    out_data_d   = out_data_q;
    out_last_d   = out_last_q;
    out_lanes_d  = out_lanes_q;
    word_count_d = word_count_q;
    if (xfer) begin
      out_valid_d  = 1'b0;
      word_count_d = word_count_q + 16'd1;
    end
    // A close in the same cycle as a transfer reloads the register and keeps it valid.
    if (close) begin
      out_valid_d = 1'b1;
      out_data_d  = closed_word;
      out_last_d  = in_last;
      out_lanes_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q        <= '0;
      asm_q        <= '0;
      out_valid_q  <= 1'b0;
      out_data_q   <= '0;
      out_last_q   <= 1'b0;
      out_lanes_q  <= '0;
      word_count_q <= '0;
    end else begin
      cnt_q        <= cnt_d;
      asm_q        <= asm_d;
      out_valid_q  <= out_valid_d;
      out_data_q   <= out_data_d;
      out_last_q   <= out_last_d;
      out_lanes_q  <= out_lanes_d;
      word_count_q <= word_count_d;
    end
  end

  assign out_valid  = out_valid_q;
  assign out_data   = out_data_q;
  assign out_last   = out_last_q;
  assign out_lanes  = out_lanes_q;
  assign word_count = word_count_q;

endmodule

// File: tb/tb_sample_packer.sv
// Directed and randomized checks of sample_packer with two lane configurations (2 and 4).
module tb_sample_packer;

  logic clk = 1'b0;
  logic reset;
  int   vec  = 0;
  int   miss = 0;

  always #5 clk = ~clk;

  // MAIN_TAP = 2 instance
  logic        a_in_valid, a_in_ready, a_in_last, a_out_valid, a_out_ready, a_out_last;
  logic [7:0]  a_in_data;
  logic [15:0] a_out_data, a_wc;
  logic [1:0]  a_out_lanes;

  // MAIN_TAP = 4 instance
  logic        b_in_valid, b_in_ready, b_in_last, b_out_valid, b_out_ready, b_out_last;
  logic [7:0]  b_in_data;
  logic [31:0] b_out_data;
  logic [15:0] b_wc;
  logic [2:0]  b_out_lanes;

  sample_packer #(.MAIN_TAP(2), .INPUT_DATA_WIDTH(8)) dut2 (
    .clk(clk), .reset(reset),
    .in_valid(a_in_valid), .in_ready(a_in_ready), .in_data(a_in_data), .in_last(a_in_last),
    .out_valid(a_out_valid), .out_ready(a_out_ready), .out_data(a_out_data),
    .out_last(a_out_last), .out_lanes(a_out_lanes), .word_count(a_wc)
  );

  sample_packer #(.MAIN_TAP(4), .INPUT_DATA_WIDTH(8)) dut4 (
    .clk(clk), .reset(reset),
    .in_valid(b_in_valid), .in_ready(b_in_ready), .in_data(b_in_data), .in_last(b_in_last),
    .out_valid(b_out_valid), .out_ready(b_out_ready), .out_data(b_out_data),
    .out_last(b_out_last), .out_lanes(b_out_lanes), .word_count(b_wc)
  );

  task automatic test_reset();
    reset = 1'b1;
    a_in_valid = 0; a_in_last = 0; a_in_data = 0; a_out_ready = 0;
    b_in_valid = 0; b_in_last = 0; b_in_data = 0; b_out_ready = 0;
    repeat (2) @(posedge clk);
    #1;
    vec++;
    if ({a_out_valid, a_out_last, a_out_lanes, a_out_data, a_wc} !== 35'd0) begin
      miss++;
      $display("FAIL reset_a: got v=%b l=%b n=%0d d=%h wc=%0d expected all zero",
               a_out_valid, a_out_last, a_out_lanes, a_out_data, a_wc);
    end
    vec++;
    if ({b_out_valid, b_out_last, b_out_lanes, b_out_data, b_wc} !== 52'd0) begin
      miss++;
      $display("FAIL reset_b: got v=%b l=%b n=%0d d=%h wc=%0d expected all zero",
               b_out_valid, b_out_last, b_out_lanes, b_out_data, b_wc);
    end
    reset = 1'b0;
    $display("reset: outputs checked");
  endtask

  task automatic test_reset_midword();
    a_out_ready = 0;
    a_in_valid = 1; a_in_last = 0; a_in_data = 8'h55;
    @(posedge clk); #1;
    a_in_data = 8'h66;
    @(posedge clk); #1;
    a_in_data = 8'h11;
    @(posedge clk); #1;
    a_in_valid = 0;
    vec++;
    if (a_out_valid !== 1'b1 || a_out_data !== 16'h6655) begin
      miss++;
      $display("FAIL midreset_pre: got v=%b d=%h expected v=1 d=6655", a_out_valid, a_out_data);
    end
    #2 reset = 1'b1;
    #1;
    vec++;
    if ({a_out_valid, a_out_last, a_out_lanes, a_out_data, a_wc} !== 35'd0) begin
      miss++;
      $display("FAIL midreset_async: got v=%b l=%b n=%0d d=%h wc=%0d expected all zero",
               a_out_valid, a_out_last, a_out_lanes, a_out_data, a_wc);
    end
    #1 reset = 1'b0;
    a_out_ready = 1;
    a_in_valid = 1; a_in_data = 8'h22;
    @(posedge clk); #1;
    a_in_data = 8'h33;
    @(posedge clk); #1;
    a_in_valid = 0;
    vec++;
    if (a_out_valid !== 1'b1 || a_out_data !== 16'h3322 || a_out_lanes !== 2'd2 || a_out_last !== 1'b0) begin
      miss++;
      $display("FAIL midreset_word: got v=%b d=%h n=%0d l=%b expected v=1 d=3322 n=2 l=0",
               a_out_valid, a_out_data, a_out_lanes, a_out_last);
    end
    @(posedge clk); #1;
    vec++;
    if (a_out_valid !== 1'b0 || a_wc !== 16'd1 || a_out_data !== 16'h3322) begin
      miss++;
      $display("FAIL midreset_xfer: got v=%b wc=%0d d=%h expected v=0 wc=1 d=3322",
               a_out_valid, a_wc, a_out_data);
    end
    $display("reset mid-word: word 3322 checked");
  endtask

  task automatic test_streaming();
    b_out_ready = 1;
    for (int i = 1; i <= 8; i++) begin
      b_in_valid = 1; b_in_last = 0; b_in_data = 8'(i);
      #1;
      vec++;
      if (b_in_ready !== 1'b1) begin
        miss++;
        $display("FAIL stream_ready[%0d]: got %b expected 1", i, b_in_ready);
      end
      @(posedge clk); #1;
      if (i == 4 || i == 8) begin
        vec++;
        if (b_out_valid !== 1'b1 || b_out_data !== ((i == 4) ? 32'h04030201 : 32'h08070605) ||
            b_out_lanes !== 3'd4 || b_out_last !== 1'b0) begin
          miss++;
          $display("FAIL stream_word[%0d]: got v=%b d=%h n=%0d l=%b expected v=1 d=%h n=4 l=0",
                   i, b_out_valid, b_out_data, b_out_lanes, b_out_last,
                   (i == 4) ? 32'h04030201 : 32'h08070605);
        end
      end else if (i == 5) begin
        vec++;
        if (b_out_valid !== 1'b0 || b_wc !== 16'd1) begin
          miss++;
          $display("FAIL stream_first_xfer: got v=%b wc=%0d expected v=0 wc=1", b_out_valid, b_wc);
        end
      end
    end
    b_in_valid = 0;
    @(posedge clk); #1;
    vec++;
    if (b_out_valid !== 1'b0 || b_wc !== 16'd2) begin
      miss++;
      $display("FAIL stream_count: got v=%b wc=%0d expected v=0 wc=2", b_out_valid, b_wc);
    end
    $display("streaming: words 04030201, 08070605 checked");
  endtask

  task automatic test_backpressure();
    a_out_ready = 0;
    a_in_valid = 1; a_in_last = 0; a_in_data = 8'hA1;
    @(posedge clk); #1;
    a_in_data = 8'hA2;
    @(posedge clk); #1;
    vec++;
    if (a_out_valid !== 1'b1 || a_out_data !== 16'hA2A1) begin
      miss++;
      $display("FAIL bp_first: got v=%b d=%h expected v=1 d=a2a1", a_out_valid, a_out_data);
    end
    a_in_data = 8'hB1;
    #1;
    vec++;
    if (a_in_ready !== 1'b1) begin
      miss++;
      $display("FAIL bp_b1_ready: got %b expected 1", a_in_ready);
    end
    @(posedge clk); #1;
    a_in_data = 8'hB2;
    #1;
    vec++;
    if (a_in_ready !== 1'b0) begin
      miss++;
      $display("FAIL bp_b2_stall: got %b expected 0", a_in_ready);
    end
    @(posedge clk); #1;
    vec++;
    if (a_out_valid !== 1'b1 || a_out_data !== 16'hA2A1 || a_wc !== 16'd1) begin
      miss++;
      $display("FAIL bp_hold: got v=%b d=%h wc=%0d expected v=1 d=a2a1 wc=1",
               a_out_valid, a_out_data, a_wc);
    end
    a_out_ready = 1;
    #1;
    vec++;
    if (a_in_ready !== 1'b1) begin
      miss++;
      $display("FAIL bp_release_ready: got %b expected 1", a_in_ready);
    end
    @(posedge clk); #1;
    a_in_valid = 0;
    vec++;
    if (a_out_valid !== 1'b1 || a_out_data !== 16'hB2B1 || a_wc !== 16'd2) begin
      miss++;
      $display("FAIL bp_reload: got v=%b d=%h wc=%0d expected v=1 d=b2b1 wc=2",
               a_out_valid, a_out_data, a_wc);
    end
    @(posedge clk); #1;
    vec++;
    if (a_out_valid !== 1'b0 || a_wc !== 16'd3) begin
      miss++;
      $display("FAIL bp_drain: got v=%b wc=%0d expected v=0 wc=3", a_out_valid, a_wc);
    end
    $display("back-pressure: a2a1 held, b2b1 reloaded checked");
  endtask

  task automatic test_short_word();
    b_out_ready = 1;
    b_in_valid = 1; b_in_last = 0; b_in_data = 8'h10;
    @(posedge clk); #1;
    b_in_last = 1; b_in_data = 8'h20;
    @(posedge clk); #1;
    vec++;
    if (b_out_valid !== 1'b1 || b_out_data !== 32'h00002010 || b_out_lanes !== 3'd2 || b_out_last !== 1'b1) begin
      miss++;
      $display("FAIL short_word: got v=%b d=%h n=%0d l=%b expected v=1 d=00002010 n=2 l=1",
               b_out_valid, b_out_data, b_out_lanes, b_out_last);
    end
    b_in_valid = 0; b_in_last = 1; b_in_data = 8'h99;
    repeat (2) @(posedge clk);
    #1;
    vec++;
    if (b_out_valid !== 1'b0 || b_wc !== 16'd3) begin
      miss++;
      $display("FAIL short_idle_last: got v=%b wc=%0d expected v=0 wc=3", b_out_valid, b_wc);
    end
    b_in_valid = 1; b_in_last = 1; b_in_data = 8'h30;
    @(posedge clk); #1;
    b_in_valid = 0; b_in_last = 0;
    vec++;
    if (b_out_valid !== 1'b1 || b_out_data !== 32'h00000030 || b_out_lanes !== 3'd1 || b_out_last !== 1'b1) begin
      miss++;
      $display("FAIL short_lane0: got v=%b d=%h n=%0d l=%b expected v=1 d=00000030 n=1 l=1",
               b_out_valid, b_out_data, b_out_lanes, b_out_last);
    end
    @(posedge clk); #1;
    $display("short word: 00002010 and single-lane 00000030 checked");
  endtask

  task automatic test_wrap();
    #2 reset = 1'b1;
    #1;
    vec++;
    if (b_wc !== 16'd0) begin
      miss++;
      $display("FAIL wrap_reset_count: got %0d expected 0", b_wc);
    end
    #1 reset = 1'b0;
    b_out_ready = 1; b_in_valid = 1; b_in_last = 1;
    for (int i = 0; i < 65536; i++) begin
      b_in_data = i[7:0];
      @(posedge clk); #1;
    end
    b_in_valid = 0; b_in_last = 0;
    vec++;
    if (b_wc !== 16'hFFFF || b_out_valid !== 1'b1 || b_out_data !== 32'h000000FF) begin
      miss++;
      $display("FAIL wrap_pre: got wc=%h v=%b d=%h expected wc=ffff v=1 d=000000ff",
               b_wc, b_out_valid, b_out_data);
    end
    @(posedge clk); #1;
    vec++;
    if (b_wc !== 16'd0 || b_out_valid !== 1'b0 || b_out_data !== 32'h000000FF || b_out_lanes !== 3'd1) begin
      miss++;
      $display("FAIL wrap_zero: got wc=%h v=%b d=%h n=%0d expected wc=0 v=0 d=000000ff n=1",
               b_wc, b_out_valid, b_out_data, b_out_lanes);
    end
    $display("counter wrap: 65536 transfers checked");
  endtask

  task automatic test_random();
    logic [18:0] expq[$];
    logic [7:0]  m_lane[2];
    logic [18:0] got, want, stall_word;
    logic        acc, xf, stall, closing;
    int          mcnt, nsent, nxfer;
    acc = 0; mcnt = 0; nsent = 0; nxfer = 0;
    a_in_valid = 0; a_in_last = 0;
    while (nsent < 1500) begin
      if (!a_in_valid || acc) begin
        a_in_valid = ($urandom_range(0, 9) < 7);
        a_in_data  = 8'($urandom);
        a_in_last  = ($urandom_range(0, 4) == 0);
      end
      a_out_ready = ($urandom_range(0, 9) < 6);
      #1;
      closing = (mcnt == 1) || a_in_last;
      if (a_in_valid && !closing) begin
        vec++;
        if (a_in_ready !== 1'b1) begin
          miss++;
          $display("FAIL rnd_nonclose_ready: got %b expected 1", a_in_ready);
        end
      end
      if (a_in_valid && closing && a_out_valid && !a_out_ready) begin
        vec++;
        if (a_in_ready !== 1'b0) begin
          miss++;
          $display("FAIL rnd_close_stall: got %b expected 0", a_in_ready);
        end
      end
      acc   = a_in_valid && a_in_ready;
      xf    = a_out_valid && a_out_ready;
      stall = a_out_valid && !a_out_ready;
      got   = {a_out_last, a_out_lanes, a_out_data};
      stall_word = got;
      @(posedge clk); #1;
      if (xf) begin
        nxfer++;
        vec++;
        if (expq.size() == 0) begin
          miss++;
          $display("FAIL rnd_extra_word: got %h expected no word", got);
        end else begin
          want = expq.pop_front();
          if (got !== want) begin
            miss++;
            $display("FAIL rnd_word: got last/lanes/data %h expected %h", got, want);
          end
        end
      end
      if (stall) begin
        vec++;
        if (a_out_valid !== 1'b1 || {a_out_last, a_out_lanes, a_out_data} !== stall_word) begin
          miss++;
          $display("FAIL rnd_stall_stable: got v=%b %h expected v=1 %h",
                   a_out_valid, {a_out_last, a_out_lanes, a_out_data}, stall_word);
        end
      end
      if (acc) begin
        m_lane[mcnt] = a_in_data;
        nsent++;
        if (closing) begin
          if (mcnt == 1) expq.push_back({a_in_last, 2'd2, m_lane[1], m_lane[0]});
          else           expq.push_back({a_in_last, 2'd1, 8'h00, m_lane[0]});
          mcnt = 0;
        end else begin
          mcnt = 1;
        end
      end
    end
    a_in_valid = 0; a_in_last = 0; a_out_ready = 1;
    for (int c = 0; c < 4; c++) begin
      #1;
      xf  = a_out_valid;
      got = {a_out_last, a_out_lanes, a_out_data};
      @(posedge clk); #1;
      if (xf) begin
        nxfer++;
        vec++;
        want = (expq.size() != 0) ? expq.pop_front() : 19'h7FFFF;
        if (got !== want) begin
          miss++;
          $display("FAIL rnd_drain_word: got %h expected %h", got, want);
        end
      end
    end
    vec++;
    if (expq.size() != 0 || a_wc !== 16'(nxfer)) begin
      miss++;
      $display("FAIL rnd_totals: got %0d words left, wc=%0d expected 0 left, wc=%0d",
               expq.size(), a_wc, nxfer);
    end
    $display("random: %0d samples, %0d words checked", nsent, nxfer);
  endtask

  initial begin
    test_reset();
    test_reset_midword();
    test_streaming();
    test_backpressure();
    test_short_word();
    test_wrap();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
    $finish;
  end

endmodule
